// File: rtl/ue_tcam_updater.sv
// Read-modify-write rule updater for a unit-BRAM TCAM; sweeps every (unit, row) of one layer per request.
// Optional UE_TCAM_RMW_SKIP_EN: rows whose contents would not change are not written back.
module ue_tcam_updater #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 36,
  parameter int L     = 4,
  parameter int N     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_op,
  input  logic [$clog2(DEPTH)-1:0]   req_addr,
  input  logic [WIDTH-1:0]           req_value,
  input  logic [WIDTH-1:0]           req_mask,
  output logic                       mem_en,
  output logic                       mem_wen,
  output logic [((L > 1) ? $clog2(L) : 1)-1:0] mem_layer,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] mem_unit,
  output logic [WIDTH/N-1:0]         mem_row,
  output logic [DEPTH/L-1:0]         mem_wdata,
  input  logic [DEPTH/L-1:0]         mem_rdata,
  output logic                       busy,
  output logic                       done
);

  localparam int SW = WIDTH / N;
  localparam int SA = DEPTH / L;
  localparam int CW = $clog2(SA);
  localparam int LW = (L > 1) ? $clog2(L) : 1;
  localparam int UW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, RD, MOD, WR, DONE} state_t;

  state_t            state, state_next;
  logic              op_q;
  logic [CW-1:0]     col_q;
  logic [LW-1:0]     layer_q;
  logic [WIDTH-1:0]  value_q;
  logic [WIDTH-1:0]  mask_q;
  logic [UW-1:0]     unit;
  logic [SW-1:0]     row;
  logic [SA-1:0]     row_buf;
  logic [SA-1:0]     new_row;
  logic [SW-1:0]     sub_val;
  logic [SW-1:0]     sub_mask;
  logic              hit;
  logic              last;
  logic              advance;

  // Column bit for this row: 1 only when the row index matches the rule slice on cared bits.
  always_comb begin
    sub_val  = value_q[int'(unit)*SW +: SW];
    sub_mask = mask_q[int'(unit)*SW +: SW];
    hit      = op_q && (((row ^ sub_val) & ~sub_mask) == '0);
    new_row  = mem_rdata;
    new_row[col_q] = hit;
  end

  assign last = (unit == UW'(N - 1)) && (row == '1);

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    mem_en     = 1'b0;
    mem_wen    = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_next = RD;
      end
      RD: begin
        mem_en     = 1'b1;
        state_next = MOD;
      end
      MOD: begin
`ifdef UE_TCAM_RMW_SKIP_EN
        if (new_row == mem_rdata) begin
          advance    = 1'b1;
          state_next = last ? DONE : RD;
        end else begin
          state_next = WR;
        end
`else
        state_next = WR;
`endif
      end
      WR: begin
        mem_en     = 1'b1;
        mem_wen    = 1'b1;
        advance    = 1'b1;
        state_next = last ? DONE : RD;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= 1'b0;
      col_q   <= '0;
      layer_q <= '0;
      value_q <= '0;
      mask_q  <= '0;
      unit    <= '0;
      row     <= '0;
      row_buf <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid) begin
        op_q    <= req_op;
        col_q   <= req_addr[CW-1:0];
        layer_q <= req_addr[CW +: LW];
        value_q <= req_value;
        mask_q  <= req_mask;
        unit    <= '0;
        row     <= '0;
      end
      if (state == MOD) row_buf <= new_row;
      if (advance) begin
        row <= row + 1'b1;
        if (row == '1) unit <= unit + 1'b1;
      end
    end
  end

  assign mem_layer = layer_q;
  assign mem_unit  = unit;
  assign mem_row   = row;
  assign mem_wdata = row_buf;

endmodule

// File: tb/tb_ue_tcam_updater.sv
// Directed bench for ue_tcam_updater with a behavioural unit-BRAM (DEPTH=16, WIDTH=8, L=2, N=2).
module tb_ue_tcam_updater;
  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int L     = 2;
  localparam int N     = 2;
`ifdef UE_TCAM_RMW_SKIP_EN
  localparam int REINS_DONE   = 65;
  localparam int REINS_WRITES = 0;
`else
  localparam int REINS_DONE   = 97;
  localparam int REINS_WRITES = 32;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_op = 1'b0;
  logic [3:0] req_addr = '0;
  logic [7:0] req_value = '0;
  logic [7:0] req_mask = '0;
  logic       mem_en, mem_wen;
  logic [0:0] mem_layer;
  logic [0:0] mem_unit;
  logic [3:0] mem_row;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy, done;

  logic [7:0] mem [64];
  logic [7:0] exp_mem [64];
  logic       pl_en = 1'b0;
  logic [5:0] pl_addr = '0;
  logic [7:0] pl_data = '0;
  int wr_total = 0;
  int done_total = 0;
  int checks = 0;
  int failures = 0;

  logic       k1_en, k1_wen, k1_busy, k1_ready, k33_wen;
  logic [0:0] k1_layer;
  logic [7:0] k33_wdata;

  always #5 clk = ~clk;

  ue_tcam_updater #(.DEPTH(DEPTH), .WIDTH(WIDTH), .L(L), .N(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_value(req_value), .req_mask(req_mask),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_layer(mem_layer),
    .mem_unit(mem_unit), .mem_row(mem_row), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .done(done)
  );

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (mem_en) begin
      if (mem_wen) begin
        mem[{mem_layer, mem_unit, mem_row}] <= mem_wdata;
        wr_total <= wr_total + 1;
      end else begin
        mem_rdata <= mem[{mem_layer, mem_unit, mem_row}];
      end
    end
    if (done) done_total <= done_total + 1;
  end

  task automatic run_req(input logic op, input logic [3:0] addr, input logic [7:0] val,
                         input logic [7:0] msk, input bit hold, output int done_k,
                         output int ready_k, output int writes, output int dones);
    int w0, d0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_ready got=%b want=1", req_ready);
    end
    req_valid = 1'b1; req_op = op; req_addr = addr; req_value = val; req_mask = msk;
    w0 = wr_total; d0 = done_total;
    done_k = -1; ready_k = -1;
    @(posedge clk);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) begin
        k1_en = mem_en; k1_wen = mem_wen; k1_busy = busy; k1_ready = req_ready; k1_layer = mem_layer;
        if (hold) begin
          req_op = 1'b1; req_addr = 4'h2; req_value = 8'hFF; req_mask = 8'h00;
        end else begin
          req_valid = 1'b0;
        end
      end
      if (k == 33) begin
        k33_wen = mem_wen; k33_wdata = mem_wdata;
      end
      if (done === 1'b1 && done_k < 0) begin
        done_k = k;
        req_valid = 1'b0;
      end
      if (req_ready === 1'b1) begin
        ready_k = k;
        break;
      end
    end
    req_valid = 1'b0;
    writes = wr_total - w0;
    dones  = done_total - d0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, mem_en, mem_wen} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got busy/done/en/wen=%b want=0000", {busy, done, mem_en, mem_wen});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got ready=%b busy=%b want ready=1 busy=0", req_ready, busy);
    end
  endtask

  task automatic preload();
    @(negedge clk);
    pl_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      pl_addr = 6'(i);
      pl_data = (i < 32) ? 8'hA1 : 8'h00;
      exp_mem[i] = pl_data;
      @(negedge clk);
    end
    pl_en = 1'b0;
  endtask

  task automatic test_insert_exact();
    int dk, rk, wr, dn;
    run_req(1'b1, 4'hB, 8'h5A, 8'h00, 1'b0, dk, rk, wr, dn);
    exp_mem[{1'b1, 1'b0, 4'hA}] = 8'h08;
    exp_mem[{1'b1, 1'b1, 4'h5}] = 8'h08;
    checks++; if (dk !== 97) begin failures++; $display("FAIL exact_done_cycle got=%0d want=97", dk); end
    checks++; if (rk !== 98) begin failures++; $display("FAIL exact_ready_cycle got=%0d want=98", rk); end
    checks++; if (wr !== 32) begin failures++; $display("FAIL exact_writes got=%0d want=32", wr); end
    checks++; if (dn !== 1) begin failures++; $display("FAIL exact_done_pulses got=%0d want=1", dn); end
    checks++;
    if ({k1_en, k1_wen, k1_busy, k1_ready} !== 4'b1010 || k1_layer !== 1'b1) begin
      failures++;
      $display("FAIL first_rd got en/wen/busy/ready=%b layer=%b want 1010 layer=1",
               {k1_en, k1_wen, k1_busy, k1_ready}, k1_layer);
    end
    checks++;
    if (k33_wen !== 1'b1 || k33_wdata !== 8'h08) begin
      failures++;
      $display("FAIL row_a_write got wen=%b wdata=%h want wen=1 wdata=08", k33_wen, k33_wdata);
    end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (mem[i] !== exp_mem[i]) begin failures++; $display("FAIL exact_image[%0d] got=%h want=%h", i, mem[i], exp_mem[i]); end
    end
  endtask

  task automatic test_insert_masked();
    int dk, rk, wr, dn;
    run_req(1'b1, 4'h2, 8'h30, 8'h0F, 1'b0, dk, rk, wr, dn);
    for (int r = 0; r < 16; r++) exp_mem[{1'b0, 1'b0, 4'(r)}] = 8'hA5;
    exp_mem[{1'b0, 1'b1, 4'h3}] = 8'hA5;
    checks++; if (k1_layer !== 1'b0) begin failures++; $display("FAIL masked_layer got=%b want=0", k1_layer); end
    checks++; if (dk !== 97 || wr !== 32) begin failures++; $display("FAIL masked_timing got done=%0d writes=%0d want 97/32", dk, wr); end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (mem[i] !== exp_mem[i]) begin failures++; $display("FAIL masked_image[%0d] got=%h want=%h", i, mem[i], exp_mem[i]); end
    end
  endtask

  task automatic test_delete();
    int dk, rk, wr, dn;
    run_req(1'b0, 4'h2, 8'h30, 8'h0F, 1'b0, dk, rk, wr, dn);
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'hA1;
    checks++; if (dk !== 97 || wr !== 32) begin failures++; $display("FAIL delete_timing got done=%0d writes=%0d want 97/32", dk, wr); end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (mem[i] !== exp_mem[i]) begin failures++; $display("FAIL delete_image[%0d] got=%h want=%h", i, mem[i], exp_mem[i]); end
    end
  endtask

  task automatic test_busy_ignore();
    int dk, rk, wr, dn;
    run_req(1'b1, 4'h9, 8'h0F, 8'hF0, 1'b1, dk, rk, wr, dn);
    exp_mem[{1'b1, 1'b0, 4'hF}] = 8'h02;
    for (int r = 0; r < 16; r++) exp_mem[{1'b1, 1'b1, 4'(r)}] = exp_mem[{1'b1, 1'b1, 4'(r)}] | 8'h02;
    checks++; if (dk !== 97) begin failures++; $display("FAIL busy_done_cycle got=%0d want=97", dk); end
    checks++; if (rk !== 98) begin failures++; $display("FAIL busy_ready_cycle got=%0d want=98", rk); end
    checks++; if (wr !== 32 || dn !== 1) begin failures++; $display("FAIL busy_counts got writes=%0d dones=%0d want 32/1", wr, dn); end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (mem[i] !== exp_mem[i]) begin failures++; $display("FAIL busy_image[%0d] got=%h want=%h", i, mem[i], exp_mem[i]); end
    end
  endtask

  task automatic test_reset_abort();
    int w0, d0;
    logic bad_busy;
    @(negedge clk);
    req_valid = 1'b1; req_op = 1'b1; req_addr = 4'hC; req_value = 8'h00; req_mask = 8'hFF;
    w0 = wr_total; d0 = done_total;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (k == 10) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({mem_en, busy, done, req_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL abort_outputs got en/busy/done/ready=%b want=0001", {mem_en, busy, done, req_ready});
    end
    bad_busy = 1'b0;
    repeat (120) begin
      @(negedge clk);
      if (busy !== 1'b0) bad_busy = 1'b1;
    end
    checks++; if (bad_busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=1 want=0"); end
    checks++; if (done_total - d0 !== 0) begin failures++; $display("FAIL abort_done got=%0d want=0", done_total - d0); end
    checks++; if (wr_total - w0 !== 3) begin failures++; $display("FAIL abort_writes got=%0d want=3", wr_total - w0); end
    for (int r = 0; r < 3; r++) exp_mem[{1'b1, 1'b0, 4'(r)}] = exp_mem[{1'b1, 1'b0, 4'(r)}] | 8'h10;
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (mem[i] !== exp_mem[i]) begin failures++; $display("FAIL abort_image[%0d] got=%h want=%h", i, mem[i], exp_mem[i]); end
    end
  endtask

  task automatic test_reinsert();
    int dk, rk, wr, dn;
    run_req(1'b1, 4'h9, 8'h0F, 8'hF0, 1'b0, dk, rk, wr, dn);
    checks++; if (dk !== REINS_DONE) begin failures++; $display("FAIL reins_done_cycle got=%0d want=%0d", dk, REINS_DONE); end
    checks++; if (rk !== REINS_DONE + 1) begin failures++; $display("FAIL reins_ready_cycle got=%0d want=%0d", rk, REINS_DONE + 1); end
    checks++; if (wr !== REINS_WRITES) begin failures++; $display("FAIL reins_writes got=%0d want=%0d", wr, REINS_WRITES); end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (mem[i] !== exp_mem[i]) begin failures++; $display("FAIL reins_image[%0d] got=%h want=%h", i, mem[i], exp_mem[i]); end
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_insert_exact();
    test_insert_masked();
    test_delete();
    test_busy_ignore();
    test_reset_abort();
    test_reinsert();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ue_tcam_updater.md
UE_TCAM_UPDATER -- requirements
Module: ue_tcam_updater

Interface
REQ-001 SHALL have parameter DEPTH, default 512, total TCAM entries.
REQ-002 SHALL have parameter WIDTH, default 36, rule key width in bits.
REQ-003 SHALL have parameter L, default 4, vertical partitions (layers).
REQ-004 SHALL have parameter N, default 4, horizontal partitions (subword units); SW=WIDTH/N, SA=DEPTH/L, R=N*2^SW.
REQ-005 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port req_valid  in  1  rule update request.
REQ-008 SHALL have port req_ready  out  1  updater can accept a request.
REQ-009 SHALL have port req_op  in  1  1=insert, 0=delete.
REQ-010 SHALL have port req_addr  in  $clog2(DEPTH)  entry address; upper bits select layer, lower $clog2(SA) bits select column bit.
REQ-011 SHALL have port req_value  in  WIDTH  rule value.
REQ-012 SHALL have port req_mask  in  WIDTH  rule mask, 1 = don't care.
REQ-013 SHALL have port mem_en  out  1  unit-BRAM access strobe.
REQ-014 SHALL have port mem_wen  out  1  write when 1, read when 0 (qualified by mem_en).
REQ-015 SHALL have port mem_layer  out  $clog2(L)  target layer.
REQ-016 SHALL have port mem_unit  out  $clog2(N)  target subword unit.
REQ-017 SHALL have port mem_row  out  SW  target row.
REQ-018 SHALL have port mem_wdata  out  SA  row write data.
REQ-019 SHALL have port mem_rdata  in  SA  row read data, valid the cycle after a read.
REQ-020 SHALL have port busy  out  1  update in progress; port done  out  1  one-cycle completion pulse.

Function
REQ-021 SHALL accept a request on a rising edge where req_valid && req_ready, latching op, addr, value, mask; req_ready SHALL be 1 only in IDLE.
REQ-022 SHALL run FSM IDLE -> RD -> MOD -> WR -> (RD next row | DONE) -> IDLE.
REQ-023 SHALL iterate unit j = 0..N-1 outer, row c = 0..2^SW-1 inner, mem_layer constant = latched layer.
REQ-024 RD: mem_en=1, mem_wen=0, mem_unit=j, mem_row=c.
REQ-025 MOD: register new row = mem_rdata with bit addr_low replaced by b; mem_en=0.
REQ-026 b SHALL be 1 iff op=insert and ((c XOR value_j) AND NOT mask_j) == 0, value_j/mask_j = bits [(j+1)*SW-1 : j*SW]; delete SHALL force b=0.
REQ-027 WR: mem_en=1, mem_wen=1, same unit/row, mem_wdata = registered row; all other bits of the row SHALL be preserved.
REQ-028 After WR of (j=N-1, c=2^SW-1) SHALL enter DONE: done=1 for exactly one cycle, then IDLE.
REQ-029 Accept at edge T: first RD in cycle T+1, done in cycle T+3R+1, req_ready=1 in cycle T+3R+2 (macro undefined).
REQ-030 busy SHALL be 1 in RD, MOD, WR, DONE; 0 in IDLE.
REQ-031 req_valid while busy SHALL be ignored, not queued; inputs SHALL NOT be sampled after acceptance.
REQ-032 mem_en SHALL be 0 in IDLE and DONE.

Reset
REQ-033 rst=1 SHALL force IDLE, req_ready=1 after release, busy=0, done=0, mem_en=0, mem_wen=0, counters 0.
REQ-034 rst mid-update SHALL abort immediately; partially written rows SHALL NOT be rolled back.

Configuration
REQ-035 With UE_TCAM_RMW_SKIP_EN defined, MOD SHALL go directly to next RD (or DONE) when new row equals mem_rdata, issuing no write; without it every row SHALL be written.

Verification (DEPTH=16, WIDTH=8, L=2, N=2: SW=4, SA=8, R=32)
REQ-036 Insert addr=0x0B, value=0x5A, mask=0x00 into zeroed memory -> layer 1; bit 3 set only in unit0 row 0xA and unit1 row 0x5; 32 writes; done at T+97.
REQ-037 Insert addr=0x02, value=0x30, mask=0x0F -> unit0 all 16 rows bit 2=1, unit1 only row 0x3 bit 2=1, layer 0.
REQ-038 Delete addr=0x02 after REQ-037 -> bit 2 cleared in all 32 rows, neighbouring bits 0xFB-preserved.
REQ-039 req_valid held during busy with different addr -> ignored; only original rule programmed; req_ready 0 until T+3R+2.
REQ-040 rst pulsed at cycle T+10 -> mem_en=0 next cycle, busy=0, done never pulses, new request accepted after release.
REQ-041 UE_TCAM_RMW_SKIP_EN defined, re-insert identical rule -> zero mem_wen cycles, done at T+2R+1 = T+65.
